// File: rtl/ir_nec_decoder.sv
// -----------------------------------------------------------------------------
// ir_nec_decoder
//
// Decodes the demodulated output of an IR receiver into NEC-protocol frames.
// It measures the width of each low and high phase in ticks and validates the
// leader, data bits and repeat codes. A good 32-bit frame is held on ir_data
// until the next good frame arrives.
//
// Parameters
//   TICK_DIV   clk cycles per measurement tick (500 gives 10 us at 50 MHz)
//   CHECK_INV  1 = reject frames whose command inverse byte does not match
//
// Ports
//   clk         system clock; every flop uses its rising edge
//   reset_n     asynchronous active-low reset
//   ir_rx       raw receiver output, asynchronous; idle high, carrier-on low
//   ir_data     last valid frame: [7:0] addr, [15:8] ~addr,
//               [23:16] cmd, [31:24] ~cmd
//   new_frame   1-cycle pulse when ir_data is updated
//   repeat_hit  1-cycle pulse on a valid NEC repeat code
//   frame_err   1-cycle pulse when a frame is aborted after a valid leader
//               low, or when it fails the inverse check
//   busy        high whenever the decoder is not idle
// -----------------------------------------------------------------------------
module ir_nec_decoder #(
  parameter int TICK_DIV  = 500,
  parameter bit CHECK_INV = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ir_rx,
  output logic [31:0] ir_data,
  output logic        new_frame,
  output logic        repeat_hit,
  output logic        frame_err,
  output logic        busy
);

  localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [10:0]   CNT_MAX = 11'd2047;

  // Phase windows in ticks, inclusive.
  localparam logic [10:0] LEAD_LO_MIN = 11'd800;
  localparam logic [10:0] LEAD_LO_MAX = 11'd1000;
  localparam logic [10:0] DATA_HI_MIN = 11'd400;
  localparam logic [10:0] DATA_HI_MAX = 11'd500;
  localparam logic [10:0] REP_HI_MIN  = 11'd200;
  localparam logic [10:0] REP_HI_MAX  = 11'd250;
  localparam logic [10:0] BIT_MIN     = 11'd40;
  localparam logic [10:0] BIT_MAX     = 11'd70;
  localparam logic [10:0] ONE_MIN     = 11'd140;
  localparam logic [10:0] ONE_MAX     = 11'd190;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    TAIL
  } state_t;

  function automatic logic in_win(input logic [10:0] v,
                                  input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser and edge detect. The chain resets to 1 (idle line) so the
  // release of reset never looks like a falling edge.
  // ---------------------------------------------------------------------------
  logic s1, s2, prev;
  logic fall, rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value of
      // its neighbour, which is what makes this a shift chain and not a wire.
      s1   <= ir_rx;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign fall = prev & ~s2;
  assign rise = ~prev & s2;

  // ---------------------------------------------------------------------------
  // Free-running tick prescaler. It is never realigned to line edges, so each
  // measured width carries +/-1 tick of quantisation that the windows absorb.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre;
  logic          tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            pre <= '0;
    else if (pre == PRE_MAX) pre <= '0;
    else                     pre <= pre + PW'(1);
  end

  assign tick = (pre == PRE_MAX);

  // ---------------------------------------------------------------------------
  // Width counter: ticks since the last line edge, saturating.
  // ---------------------------------------------------------------------------
  logic [10:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    cnt <= '0;
    else if (fall || rise)           cnt <= '0;
    else if (tick && cnt != CNT_MAX) cnt <= cnt + 11'd1;
  end

  // ---------------------------------------------------------------------------
  // Bit classification and the shift register value after this bit.
  // ---------------------------------------------------------------------------
  state_t      state;
  logic [4:0]  idx;
  logic [31:0] sr;
  logic        bit_zero, bit_one;
  logic [31:0] sr_shift;
  logic        inv_ok;

  assign bit_zero = in_win(cnt, BIT_MIN, BIT_MAX);
  assign bit_one  = in_win(cnt, ONE_MIN, ONE_MAX);
  // First received bit ends up in [0]; each new bit enters at [31].
  assign sr_shift = {bit_one, sr[31:1]};
  // The address inverse is deliberately ignored (extended NEC addressing).
  assign inv_ok   = !CHECK_INV || (sr_shift[31:24] == ~sr_shift[23:16]);

  // ---------------------------------------------------------------------------
  // Decoder FSM. Status pulses default low every cycle and are raised only by
  // the transition that reports them, so each lasts exactly one cycle and at
  // most one can be high at a time. busy is updated together with the state
  // so it tracks "next state is not IDLE" without a cycle of lag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      sr         <= '0;
      ir_data    <= '0;
      new_frame  <= 1'b0;
      repeat_hit <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      new_frame  <= 1'b0;
      repeat_hit <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state <= LEAD_LOW;
            busy  <= 1'b1;
          end
        end

        LEAD_LOW: begin
          if (rise) begin
            if (in_win(cnt, LEAD_LO_MIN, LEAD_LO_MAX)) begin
              state <= LEAD_HIGH;
            end else begin
              // Noise or a foreign protocol: drop it without reporting.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (cnt > LEAD_LO_MAX) begin
            state <= TAIL;
          end
        end

        LEAD_HIGH: begin
          if (fall) begin
            if (in_win(cnt, DATA_HI_MIN, DATA_HI_MAX)) begin
              idx   <= '0;
              state <= BIT_LOW;
            end else if (in_win(cnt, REP_HI_MIN, REP_HI_MAX)) begin
              repeat_hit <= 1'b1;
              state      <= TAIL;
            end else begin
              frame_err <= 1'b1;
              state     <= TAIL;
            end
          end else if (cnt > DATA_HI_MAX) begin
            frame_err <= 1'b1;
            state     <= s2 ? IDLE : TAIL;
            busy      <= ~s2;
          end
        end

        BIT_LOW: begin
          if (rise) begin
            if (bit_zero) begin
              state <= BIT_HIGH;
            end else begin
              frame_err <= 1'b1;
              state     <= TAIL;
            end
          end else if (cnt > BIT_MAX) begin
            frame_err <= 1'b1;
            state     <= s2 ? IDLE : TAIL;
            busy      <= ~s2;
          end
        end

        BIT_HIGH: begin
          if (fall) begin
            if (bit_zero || bit_one) begin
              sr <= sr_shift;
              if (idx == 5'd31) begin
                // This fall starts the stop bit; wait out its low in TAIL.
                if (inv_ok) begin
                  ir_data   <= sr_shift;
                  new_frame <= 1'b1;
                end else begin
                  frame_err <= 1'b1;
                end
                state <= TAIL;
              end else begin
                idx   <= idx + 5'd1;
                state <= BIT_LOW;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
            end
          end else if (cnt > ONE_MAX) begin
            frame_err <= 1'b1;
            state     <= s2 ? IDLE : TAIL;
            busy      <= ~s2;
          end
        end

        TAIL: begin
          if (rise) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
